// File: rtl/tile_line_fetcher.sv
// Scanline prefetch scheduler: fetches tile entries and pattern rows for the next line into a
// ping-pong line buffer and drives color_palette from the front half. Option: TILE_SCROLL_EN.
module tile_line_fetcher #(
  parameter int unsigned H_COLS   = 80,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic        CLK_100,
  input  logic        RESET_N,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [12:0] tt_addr,
  output logic        tt_rd,
  input  logic [15:0] tt_rdata,
  output logic [7:0]  get_index,
  output logic [3:0]  get_line,
  input  logic [15:0] get_data,
  output logic [2:0]  palette,
  output logic [1:0]  color_index,
  output logic        fetch_busy,
  output logic        underrun,
  input  logic        underrun_clr
`ifdef TILE_SCROLL_EN
  ,
  input  logic [8:0]  scroll_y
`endif
);

  typedef enum logic [2:0] {StIdle, StTtReq, StTtWait, StSpReq, StSpWait, StStore} state_e;

  state_e      state_q, state_d;
  logic [9:0]  drawy_q;
  logic        trig, start, last_wait, last_col;
  logic [9:0]  ny;
  logic [8:0]  fy_d, fy_q;
  logic [7:0]  col_q;
  logic [1:0]  wait_q;
  logic        front_sel_q;
  logic [1:0]  valid_q;
  logic [2:0]  pal_q;
  logic [15:0] data_q;
  logic [7:0]  get_index_q;
  logic [3:0]  get_line_q;
  logic        underrun_q;
  logic [2:0]  palette_q;
  logic [1:0]  color_q;
  logic [18:0] lb0 [H_COLS];
  logic [18:0] lb1 [H_COLS];
  logic [6:0]  x_col;
  logic [18:0] entry;
  logic        unused_tt_bits;

  assign unused_tt_bits = ^tt_rdata[15:11];

  assign trig      = (DrawY != drawy_q);
  assign ny        = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
  assign start     = trig && (ny < 10'(V_ACTIVE));
  assign last_wait = (wait_q == 2'(RD_LAT - 1));
  assign last_col  = (col_q == 8'(H_COLS - 1));

`ifdef TILE_SCROLL_EN
  logic [9:0]  scr;
  logic [10:0] fy_sum;
  always_comb begin
    scr    = (scroll_y >= 9'(V_ACTIVE)) ? 10'd0 : {1'b0, scroll_y};
    fy_sum = {1'b0, ny} + {1'b0, scr};
    fy_d   = (fy_sum >= 11'(V_ACTIVE)) ? 9'(fy_sum - 11'(V_ACTIVE)) : fy_sum[8:0];
  end
`else
  assign fy_d = ny[8:0];
`endif

  always_ff @(posedge CLK_100) begin
    if (!RESET_N) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // A line change always wins: it aborts any fetch in flight and restarts at column 0.
  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = start ? StTtReq : StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StTtReq:  state_d = StTtWait;
        StTtWait: if (last_wait) state_d = StSpReq;
        StSpReq:  state_d = StSpWait;
        StSpWait: if (last_wait) state_d = StStore;
        StStore:  state_d = last_col ? StIdle : StTtReq;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tt_rd      = (state_q == StTtReq);
    fetch_busy = (state_q != StIdle);
  end

  always_ff @(posedge CLK_100) begin
    if (!RESET_N) begin
      drawy_q     <= '0;
      fy_q        <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      front_sel_q <= 1'b0;
      valid_q     <= '0;
      pal_q       <= '0;
      data_q      <= '0;
      get_index_q <= '0;
      get_line_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      drawy_q    <= DrawY;
      underrun_q <= (trig && fetch_busy) || (underrun_q && !underrun_clr);
      if ((state_q == StTtWait || state_q == StSpWait) && !last_wait) wait_q <= wait_q + 2'd1;
      else                                                            wait_q <= '0;
      if (trig) begin
        // The old front becomes the back half and is invalid until refilled.
        front_sel_q          <= ~front_sel_q;
        valid_q[front_sel_q] <= 1'b0;
        col_q                <= '0;
        fy_q                 <= fy_d;
      end else begin
        if (state_q == StTtWait && last_wait) begin
          pal_q       <= tt_rdata[10:8];
          get_index_q <= tt_rdata[7:0];
          get_line_q  <= fy_q[3:0];
        end
        if (state_q == StSpWait && last_wait) data_q <= get_data;
        if (state_q == StStore) begin
          if (last_col) valid_q[~front_sel_q] <= 1'b1;
          else          col_q                 <= col_q + 8'd1;
        end
      end
    end
  end

  // Line buffer contents are deliberately left unreset.
  always_ff @(posedge CLK_100) begin
    if (RESET_N && !trig && state_q == StStore) begin
      if (front_sel_q) lb0[col_q[6:0]] <= {pal_q, data_q};
      else             lb1[col_q[6:0]] <= {pal_q, data_q};
    end
  end

  assign x_col = DrawX[9:3];

  always_comb begin
    entry = front_sel_q ? lb1[x_col] : lb0[x_col];
  end

  always_ff @(posedge CLK_100) begin
    if (!RESET_N) begin
      palette_q <= '0;
      color_q   <= '0;
    end else if (valid_q[front_sel_q] && x_col < 7'(H_COLS)) begin
      palette_q <= entry[18:16];
      color_q   <= 2'(entry[15:0] >> (4'd14 - {DrawX[2:0], 1'b0}));
    end else begin
      palette_q <= '0;
      color_q   <= '0;
    end
  end

  assign tt_addr     = {fy_q[8:4], col_q};
  assign get_index   = get_index_q;
  assign get_line    = get_line_q;
  assign underrun    = underrun_q;
  assign palette     = palette_q;
  assign color_index = color_q;

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Directed bench for tile_line_fetcher with behavioural tile-table and sprite_ram read ports.
module tb_tile_line_fetcher;

  logic        CLK_100;
  logic        RESET_N;
  logic [9:0]  DrawX, DrawY;
  logic [12:0] tt_addr;
  logic        tt_rd;
  logic [15:0] tt_rdata;
  logic [7:0]  get_index;
  logic [3:0]  get_line;
  logic [15:0] get_data;
  logic [2:0]  palette;
  logic [1:0]  color_index;
  logic        fetch_busy, underrun, underrun_clr;
`ifdef TILE_SCROLL_EN
  logic [8:0]  scroll_y;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_cyc, n_rd;
  logic [12:0] first_addr, last_addr;

  tile_line_fetcher dut (
    .CLK_100     (CLK_100),
    .RESET_N     (RESET_N),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .tt_addr     (tt_addr),
    .tt_rd       (tt_rd),
    .tt_rdata    (tt_rdata),
    .get_index   (get_index),
    .get_line    (get_line),
    .get_data    (get_data),
    .palette     (palette),
    .color_index (color_index),
    .fetch_busy  (fetch_busy),
    .underrun    (underrun),
    .underrun_clr(underrun_clr)
`ifdef TILE_SCROLL_EN
    ,
    .scroll_y    (scroll_y)
`endif
  );

  initial CLK_100 = 1'b0;
  always #5 CLK_100 = ~CLK_100;

  // Tile (row,col): pattern = {row[2:0],col[4:0]}+1, palette = col[2:0]^row[2:0].
  function automatic logic [15:0] tt_fn(input logic [12:0] a);
    logic [7:0] pat;
    logic [2:0] pal;
    pat = {a[10:8], a[4:0]} + 8'd1;
    pal = a[2:0] ^ a[10:8];
    return {5'd0, pal, pat};
  endfunction

  function automatic logic [15:0] sp_fn(input logic [7:0] idx, input logic [3:0] ln);
    if (idx == 8'd1 && ln == 4'd7) return 16'hCFFC;
    return {idx, ln, idx[3:0] ^ ln};
  endfunction

  // One-cycle read latency on both ports.
  always @(posedge CLK_100) begin
    tt_rdata <= tt_fn(tt_addr);
    get_data <= sp_fn(get_index, get_line);
  end

  task automatic step();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps from the line change until fetch_busy drops, recording busy cycles and tt reads.
  task automatic fetch_track();
    n_cyc = 0;
    n_rd  = 0;
    first_addr = '0;
    last_addr  = '0;
    step();
    while (fetch_busy === 1'b1 && n_cyc < 2000) begin
      if (tt_rd === 1'b1) begin
        if (n_rd == 0) first_addr = tt_addr;
        last_addr = tt_addr;
        n_rd++;
      end
      n_cyc++;
      step();
    end
  endtask

  initial begin
    RESET_N      = 1'b0;
    DrawX        = '0;
    DrawY        = '0;
    underrun_clr = 1'b0;
`ifdef TILE_SCROLL_EN
    scroll_y     = '0;
`endif
    step();
    step();
    check("rst_tt_addr", 32'(tt_addr), 32'h0);
    check("rst_tt_rd", 32'(tt_rd), 32'h0);
    check("rst_get_index", 32'(get_index), 32'h0);
    check("rst_get_line", 32'(get_line), 32'h0);
    check("rst_palette", 32'(palette), 32'h0);
    check("rst_color", 32'(color_index), 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);

    // Line 6 shown: fetch line 7.
    RESET_N = 1'b1;
    DrawY   = 10'd6;
    fetch_track();
    check("f7_cycles", 32'(n_cyc), 32'd400);
    check("f7_get_line", 32'(get_line), 32'd7);

    // Line 7 shown: fetch line 8.
    DrawY = 10'd7;
    fetch_track();
    check("f8_cycles", 32'(n_cyc), 32'd400);
    check("f8_reads", 32'(n_rd), 32'd80);
    check("f8_first_addr", 32'(first_addr), 32'h0000);
    check("f8_last_addr", 32'(last_addr), 32'h004F);
    check("f8_get_line", 32'(get_line), 32'd8);
    check("f8_underrun", 32'(underrun), 32'h0);

    // Front now holds line 7: tile (0,0) row 7 = CFFC.
    for (int x = 0; x < 8; x++) begin
      logic [15:0] pix;
      pix   = 16'hCFFC;
      DrawX = 10'(x);
      step();
      check($sformatf("l7_ci_x%0d", x), 32'(color_index), 32'(pix[15-2*x -: 2]));
      check($sformatf("l7_pal_x%0d", x), 32'(palette), 32'h0);
    end
    DrawX = 10'd42;
    step();
    check("l7_x42_pal", 32'(palette), 32'd5);
    check("l7_x42_ci", 32'(color_index), 32'd1);
    DrawX = 10'd639;
    step();
    check("l7_x639_pal", 32'(palette), 32'd7);
    check("l7_x639_ci", 32'(color_index), 32'd3);
    DrawX = 10'd640;
    step();
    check("l7_x640_pal", 32'(palette), 32'd0);
    check("l7_x640_ci", 32'(color_index), 32'd0);

    // Line change 100 cycles into the fetch of line 9.
    DrawY = 10'd8;
    repeat (100) step();
    check("ur_busy_before", 32'(fetch_busy), 32'h1);
    DrawY = 10'd9;
    step();
    check("ur_set", 32'(underrun), 32'h1);
    check("ur_restart_rd", 32'(tt_rd), 32'h1);
    check("ur_restart_addr", 32'(tt_addr), 32'h0000);
    check("ur_busy", 32'(fetch_busy), 32'h1);
    DrawX = 10'd43;
    step();
    check("ur_front_pal", 32'(palette), 32'd0);
    check("ur_front_ci", 32'(color_index), 32'd0);
    check("ur_sticky", 32'(underrun), 32'h1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("ur_cleared", 32'(underrun), 32'h0);
    n_cyc = 0;
    while (fetch_busy === 1'b1 && n_cyc < 2000) begin
      n_cyc++;
      step();
    end
    check("ur_refetch_cycles", 32'(n_cyc), 32'd398);

    // Line 10 completed before its line change, so it displays.
    DrawY = 10'd10;
    fetch_track();
    check("l10_pal", 32'(palette), 32'd5);
    check("l10_ci", 32'(color_index), 32'd2);
    check("l10_no_underrun", 32'(underrun), 32'h0);

    // Frame wrap.
    DrawY = 10'd479;
    step();
    check("w479_busy", 32'(fetch_busy), 32'h0);
    check("w479_rd", 32'(tt_rd), 32'h0);
    repeat (5) step();
    check("w479_busy_later", 32'(fetch_busy), 32'h0);
    DrawY = 10'd524;
    fetch_track();
    check("w524_cycles", 32'(n_cyc), 32'd400);
    check("w524_first_addr", 32'(first_addr), 32'h0000);
    check("w524_last_addr", 32'(last_addr), 32'h004F);
    check("w524_get_line", 32'(get_line), 32'd0);
    DrawY = 10'd0;
    DrawX = 10'd42;
    step();
    step();
    check("l0_x42_pal", 32'(palette), 32'd5);
    check("l0_x42_ci", 32'(color_index), 32'd1);
    DrawX = 10'd7;
    step();
    check("l0_x7_pal", 32'(palette), 32'd0);
    check("l0_x7_ci", 32'(color_index), 32'd1);
    check("l0_underrun", 32'(underrun), 32'h0);
    n_cyc = 0;
    while (fetch_busy === 1'b1 && n_cyc < 2000) begin
      n_cyc++;
      step();
    end
    check("l1_done", 32'(fetch_busy), 32'h0);

`ifdef TILE_SCROLL_EN
    scroll_y = 9'd16;
    DrawY    = 10'd7;
    fetch_track();
    check("s16_first_addr", 32'(first_addr), 32'h0100);
    check("s16_last_addr", 32'(last_addr), 32'h014F);
    check("s16_get_line", 32'(get_line), 32'd8);
    scroll_y = 9'd470;
    DrawY    = 10'd20;
    fetch_track();
    check("s470_first_addr", 32'(first_addr), 32'h0000);
    check("s470_last_addr", 32'(last_addr), 32'h004F);
    check("s470_get_line", 32'(get_line), 32'd11);
    scroll_y = 9'd0;
`endif

    // Reset in the middle of a fetch, then a normal restart.
    DrawY = 10'd3;
    repeat (20) step();
    RESET_N = 1'b0;
    step();
    check("mid_rst_busy", 32'(fetch_busy), 32'h0);
    check("mid_rst_rd", 32'(tt_rd), 32'h0);
    check("mid_rst_palette", 32'(palette), 32'h0);
    RESET_N = 1'b1;
    fetch_track();
    check("mid_rst_refetch", 32'(n_cyc), 32'd400);
    check("mid_rst_get_line", 32'(get_line), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
